// File: rtl/wave_phase_controller_if.sv
// Configuration handshake between the upstream config logic and the
// wave_phase_controller. The master offers a step/form/duty set; the slave
// accepts it when cfg ready is high.
interface wave_phase_controller_if #(
  parameter int unsigned ACC_WIDTH = 32
);
  logic                 valid;
  logic                 ready;
  logic [ACC_WIDTH-1:0] step;
  logic [1:0]           form;
  logic [4:0]           duty;

  modport master (output valid, output step, output form, output duty, input ready);
  modport slave  (input valid, input step, input form, input duty, output ready);
endinterface

// File: rtl/wave_phase_controller.sv
// wave_phase_controller: DDS phase accumulator and sample-rate sequencer for
// the square-wave datapath. New configurations are parked in a one-entry
// pending slot and only become active at a phase wrap (or immediately while
// idle), so downstream never sees a truncated period.
// Optional feature macro: WAVE_PHASE_SWEEP_EN (frequency sweep on each wrap).
module wave_phase_controller #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SAMPLE_DIV = 100
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  wave_phase_controller_if.slave cfg_if,
`ifdef WAVE_PHASE_SWEEP_EN
  input  logic [15:0]           i_sweep_delta,
  input  logic [ACC_WIDTH-1:0]  i_sweep_limit,
`endif
  output logic [11:0]           o_phase,
  output logic [1:0]            o_form,
  output logic [4:0]            o_square_duty,
  output logic                  o_sample_tick,
  output logic                  o_wrap,
  output logic                  o_running
);

  localparam int unsigned DIV_W    = $clog2(SAMPLE_DIV);
  localparam int unsigned SUM_W    = ACC_WIDTH + 1;
  localparam int unsigned PHASE_W  = 12;
  localparam int unsigned DUTY_MAX = 20;
  localparam int unsigned DUTY_RST = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_step;
  logic [1:0]           r_form;
  logic [4:0]           r_duty;
  logic                 r_pend_full;
  logic [ACC_WIDTH-1:0] r_pend_step;
  logic [1:0]           r_pend_form;
  logic [4:0]           r_pend_duty;
  logic                 r_cfg_ready;
  logic                 r_tick;
  logic                 r_wrap;
  logic                 r_running;

  logic                 w_tick;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_carry;
  logic                 w_step_zero;
  logic                 w_boundary;
  logic                 w_apply;
  logic                 w_capture;
  logic                 w_pend_full_nxt;
  logic [4:0]           w_duty_in;
  logic [ACC_WIDTH-1:0] w_idle_step;

  assign w_tick          = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_sum           = {1'b0, r_acc} + {1'b0, r_step};
  assign w_carry         = w_sum[ACC_WIDTH];
  assign w_step_zero     = (r_step == '0);
  // A tick that ends the current period: real wrap, or any tick with a zero step.
  assign w_boundary      = w_tick && (r_state != ST_IDLE) && (w_carry || w_step_zero);
  assign w_apply         = r_pend_full && ((r_state == ST_IDLE) || w_boundary);
  assign w_capture       = cfg_if.valid && !r_pend_full;
  assign w_pend_full_nxt = w_capture || (r_pend_full && !w_apply);
  assign w_duty_in       = (cfg_if.duty > 5'(DUTY_MAX)) ? 5'(DUTY_MAX) : cfg_if.duty;
  // A config applied on the very tick that starts the run drives the first add.
  assign w_idle_step     = w_apply ? r_pend_step : r_step;

`ifdef WAVE_PHASE_SWEEP_EN
  logic [ACC_WIDTH-1:0] r_base_step;
  logic [SUM_W-1:0]     w_sweep_sum;
  logic                 w_sweep;
  logic [ACC_WIDTH-1:0] w_sweep_step;

  assign w_sweep_sum  = {1'b0, r_step} + SUM_W'(i_sweep_delta);
  assign w_sweep      = (r_state == ST_RUN) && w_tick && w_carry && !w_apply &&
                        (i_sweep_delta != 16'd0);
  assign w_sweep_step = (w_sweep_sum > {1'b0, i_sweep_limit}) ? r_base_step
                                                               : w_sweep_sum[ACC_WIDTH-1:0];
`endif

  // Sample-rate divider; the tick strobe is registered one cycle after terminal count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_tick ? '0 : r_div + DIV_W'(1);
      r_tick <= w_tick;
    end
  end

  // One-entry pending configuration slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_full <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_pend_step <= '0;
      r_pend_form <= '0;
      r_pend_duty <= '0;
    end else begin
      r_pend_full <= w_pend_full_nxt;
      r_cfg_ready <= !w_pend_full_nxt;
      if (w_capture) begin
        r_pend_step <= cfg_if.step;
        r_pend_form <= cfg_if.form;
        r_pend_duty <= w_duty_in;
      end
    end
  end

  // Live configuration seen by the accumulator and downstream.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step <= '0;
      r_form <= '0;
      r_duty <= 5'(DUTY_RST);
`ifdef WAVE_PHASE_SWEEP_EN
      r_base_step <= '0;
`endif
    end else if (w_apply) begin
      r_step <= r_pend_step;
      r_form <= r_pend_form;
      r_duty <= r_pend_duty;
`ifdef WAVE_PHASE_SWEEP_EN
      r_base_step <= r_pend_step;
    end else if (w_sweep) begin
      r_step <= w_sweep_step;
`endif
    end
  end

  // Run-state sequencer and phase accumulator.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_acc     <= '0;
          r_running <= w_tick && i_enable;
          if (w_tick && i_enable) begin
            r_acc   <= w_idle_step;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_running <= 1'b1;
          if (w_tick) begin
            r_acc  <= w_sum[ACC_WIDTH-1:0];
            r_wrap <= w_carry;
          end
          if (!i_enable) r_state <= ST_STOPPING;
        end
        ST_STOPPING: begin
          r_running <= i_enable || !w_boundary;
          if (w_tick) begin
            r_acc  <= w_sum[ACC_WIDTH-1:0];
            r_wrap <= w_carry;
          end
          if (i_enable) begin
            r_state <= ST_RUN;
          end else if (w_boundary) begin
            r_acc   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_acc     <= '0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_phase       = r_acc[ACC_WIDTH-1 -: PHASE_W];
  assign o_form        = r_form;
  assign o_square_duty = r_duty;
  assign o_sample_tick = r_tick;
  assign o_wrap        = r_wrap;
  assign o_running     = r_running;
  assign cfg_if.ready  = r_cfg_ready;

endmodule

// File: tb/tb_wave_phase_controller.sv
// Bench for wave_phase_controller: directed scenarios with fixed expected
// phase sequences, then randomized traffic checked every cycle against a
// transaction-level model of the sequencer.
module tb_wave_phase_controller;

  localparam int unsigned SD    = 4;
  localparam longint      TWO32 = 64'sh1_0000_0000;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] phase;
  logic [1:0]  form;
  logic [4:0]  duty;
  logic        tick;
  logic        wrap;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  wave_phase_controller_if #(.ACC_WIDTH(32)) cfg_if ();

  wave_phase_controller #(.ACC_WIDTH(32), .SAMPLE_DIV(SD)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .cfg_if        (cfg_if.slave),
    .o_phase       (phase),
    .o_form        (form),
    .o_square_duty (duty),
    .o_sample_tick (tick),
    .o_wrap        (wrap),
    .o_running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 stopping.
  int     m_mode, m_edges, m_form, m_duty, m_pform, m_pduty;
  longint m_acc, m_step, m_pstep;
  bit     m_pend, m_tick, m_wrap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_apply();
    m_step = m_pstep;
    m_form = m_pform;
    m_duty = m_pduty;
    m_pend = 1'b0;
  endtask

  task automatic model_edge();
    bit     hs;
    bit     bnd;
    int     old;
    longint sum;
    if (rst) begin
      m_mode = 0; m_acc = 0; m_step = 0; m_form = 0; m_duty = 10;
      m_pend = 1'b0; m_edges = 0; m_tick = 1'b0; m_wrap = 1'b0;
      return;
    end
    m_tick = ((m_edges % SD) == SD - 1);
    m_edges++;
    hs     = cfg_if.valid && !m_pend;
    m_wrap = 1'b0;
    bnd    = 1'b0;
    old    = m_mode;
    if (old == 0) begin
      if (m_pend) m_apply();
      if (m_tick && en) begin
        m_acc  = m_step;
        m_mode = 1;
      end
    end else begin
      if (m_tick) begin
        sum    = m_acc + m_step;
        m_wrap = (sum >= TWO32);
        m_acc  = sum % TWO32;
        bnd    = m_wrap || (m_step == 0);
        if (bnd && m_pend) m_apply();
      end
      if (en) m_mode = 1;
      else if (old == 1) m_mode = 2;
      else if (bnd) begin
        m_acc  = 0;
        m_mode = 0;
      end
    end
    if (hs) begin
      m_pend  = 1'b1;
      m_pstep = longint'(cfg_if.step);
      m_pform = int'(cfg_if.form);
      m_pduty = (cfg_if.duty > 5'd20) ? 20 : int'(cfg_if.duty);
    end
  endtask

  task automatic compare_all();
    check("phase",   64'(phase),        64'(m_acc >> 20));
    check("form",    64'(form),         64'(m_form));
    check("duty",    64'(duty),         64'(m_duty));
    check("tick",    64'(tick),         64'(m_tick));
    check("wrap",    64'(wrap),         64'(m_wrap));
    check("running", 64'(running),      64'(m_mode != 0));
    check("ready",   64'(cfg_if.ready), 64'(!m_pend));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic offer(input logic [31:0] s, input logic [1:0] f, input logic [4:0] d);
    cfg_if.valid = 1'b1;
    cfg_if.step  = s;
    cfg_if.form  = f;
    cfg_if.duty  = d;
    cycle();
    cfg_if.valid = 1'b0;
  endtask

  task automatic expect_tick(input string tag, input int exp_phase, input bit exp_wrap);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * SD && !seen; i++) begin
      cycle();
      if (tick) seen = 1'b1;
    end
    check({tag, "_tick_seen"}, 64'(seen), 64'(1));
    check({tag, "_phase"}, 64'(phase), 64'(exp_phase));
    check({tag, "_wrap"}, 64'(wrap), 64'(exp_wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    cfg_if.valid = 1'b0; cfg_if.step = '0; cfg_if.form = '0; cfg_if.duty = '0;
    repeat (3) cycle();
    check("rst_phase", 64'(phase), 64'(0));
    check("rst_duty",  64'(duty),  64'(10));
    check("rst_ready", 64'(cfg_if.ready), 64'(1));
    rst = 1'b0;

    // Basic ramp with a quarter-turn step.
    offer(32'h4000_0000, 2'd0, 5'd10);
    en = 1'b1;
    expect_tick("ramp1", 1024, 1'b0);
    expect_tick("ramp2", 2048, 1'b0);
    expect_tick("ramp3", 3072, 1'b0);
    expect_tick("ramp4", 0, 1'b1);
    check("ramp_running", 64'(running), 64'(1));

    // Mid-period reconfiguration waits for the wrap.
    expect_tick("mid0", 1024, 1'b0);
    offer(32'h8000_0000, 2'd2, 5'd5);
    check("mid_ready_drop", 64'(cfg_if.ready), 64'(0));
    expect_tick("mid1", 2048, 1'b0);
    check("mid_form_old", 64'(form), 64'(0));
    expect_tick("mid2", 3072, 1'b0);
    expect_tick("mid3", 0, 1'b1);
    check("mid_form_new", 64'(form), 64'(2));
    check("mid_duty_new", 64'(duty), 64'(5));
    cycle();
    check("mid_ready_back", 64'(cfg_if.ready), 64'(1));
    expect_tick("mid4", 2048, 1'b0);
    expect_tick("mid5", 0, 1'b1);

    // Back to quarter step (duty clamped), then stop at next wrap.
    offer(32'h4000_0000, 2'd1, 5'd25);
    expect_tick("stp0", 2048, 1'b0);
    expect_tick("stp1", 0, 1'b1);
    check("clamp_duty", 64'(duty), 64'(20));
    expect_tick("stp2", 1024, 1'b0);
    expect_tick("stp3", 2048, 1'b0);
    en = 1'b0;
    expect_tick("stp4", 3072, 1'b0);
    check("stp_running", 64'(running), 64'(1));
    expect_tick("stp5", 0, 1'b1);
    check("stp_idle", 64'(running), 64'(0));
    expect_tick("stp6", 0, 1'b0);
    expect_tick("stp7", 0, 1'b0);

    // Zero step while running: pending applies on the next tick without a wrap.
    offer(32'h0, 2'd0, 5'd10);
    cycle();
    en = 1'b1;
    expect_tick("z0", 0, 1'b0);
    check("z_running", 64'(running), 64'(1));
    offer(32'h2000_0000, 2'd3, 5'd7);
    expect_tick("z1", 0, 1'b0);
    check("z_form", 64'(form), 64'(3));
    expect_tick("z2", 512, 1'b0);
    expect_tick("z3", 1024, 1'b0);

    // Reset while stopping with a pending entry discards it.
    offer(32'h6000_0000, 2'd3, 5'd3);
    en = 1'b0;
    cycle();
    check("pre_rst_ready", 64'(cfg_if.ready), 64'(0));
    check("pre_rst_running", 64'(running), 64'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mrst_phase", 64'(phase), 64'(0));
    check("mrst_form", 64'(form), 64'(0));
    check("mrst_duty", 64'(duty), 64'(10));
    check("mrst_ready", 64'(cfg_if.ready), 64'(1));
    check("mrst_running", 64'(running), 64'(0));
    cycle();
    en = 1'b1;
    expect_tick("post_rst", 0, 1'b0);
    check("post_rst_form", 64'(form), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      cfg_if.valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0:       cfg_if.step = 32'h0;
        1:       cfg_if.step = 32'h4000_0000;
        2:       cfg_if.step = 32'h8000_0000;
        3:       cfg_if.step = $urandom();
        default: cfg_if.step = $urandom() >> 3;
      endcase
      cfg_if.form = 2'($urandom_range(0, 3));
      cfg_if.duty = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_phase_controller.md
Name: wave_phase_controller

Overview:
- Sequences the square-wave datapath: generates the 12-bit PHASE ramp from a DDS phase accumulator at a fixed sample rate.
- Owns the live FORM/SQUARE_DUTY/frequency configuration and applies new settings only at a phase wrap, so no truncated or glitched periods reach the DAC.
- Sits between the front-panel/UART config logic (upstream) and the wave generator + DAC driver (downstream).

Parameters:
- ACC_WIDTH, 32, phase accumulator width in bits; PHASE is the top 12 bits.
- SAMPLE_DIV, 100, CLK cycles per sample tick (1 MHz at 100 MHz CLK); legal range ≥ 2.

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  level; 1 = run output, 0 = stop at next wrap.
- CFG_VALID  input  1  new configuration offered.
- CFG_READY  output  1  pending slot empty; transfer occurs when CFG_VALID && CFG_READY.
- CFG_STEP  input  ACC_WIDTH  phase increment per sample tick.
- CFG_FORM  input  2  waveform form code.
- CFG_DUTY  input  5  duty in 5 % units, 0..20.
- PHASE  output  12  accumulator[ACC_WIDTH-1 -: 12].
- FORM  output  2  active form code.
- SQUARE_DUTY  output  5  active duty.
- SAMPLE_TICK  output  1  one-cycle pulse per sample; downstream samples PHASE/config on it.
- WRAP  output  1  one-cycle pulse, coincident with SAMPLE_TICK, when the accumulator add carries out.
- RUNNING  output  1  high in RUN or STOPPING.

Behaviour:
- Reset values: acc = 0, PHASE = 0, FORM = 0, SQUARE_DUTY = 10, active step = 0, pending empty, CFG_READY = 1, SAMPLE_TICK = 0, WRAP = 0, RUNNING = 0, divider = 0, state = IDLE.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. SAMPLE_TICK is registered and asserts in the cycle after the count equals SAMPLE_DIV-1. The divider runs in all states.
- Accumulator: on a tick in RUN or STOPPING, acc <= acc + step, modulo 2^ACC_WIDTH. WRAP = carry-out of that add. PHASE updates in the same cycle SAMPLE_TICK and WRAP assert.
- Pending buffer: a single entry holding step, form and duty.
  - CFG_READY = !pending_full.
  - Captured on the handshake; becomes applicable from the next cycle.
  - Cleared in the cycle it is applied.
  - A capture and an apply never occur on the same entry in the same cycle.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: acc held at 0. A pending entry is applied on the next cycle without waiting for a tick. ENABLE = 1 → RUN at the next tick; that tick performs the first add.
  - RUN: a pending entry is applied on a tick where WRAP = 1, and the new step takes effect from the following tick. If active step = 0, the pending entry is applied at the next tick regardless of WRAP. ENABLE = 0 → STOPPING.
  - STOPPING: keeps accumulating. On a WRAP tick, or the next tick if step = 0: acc <= 0, apply pending if present, → IDLE. ENABLE = 1 again before that → RUN, with no discontinuity.
- Simultaneous events:
  - A WRAP tick with a pending entry applies that entry.
  - A handshake in the same cycle is impossible, because READY = 0 while the entry is full.
- RESET mid-operation: returns everything to the reset values within one cycle; any pending entry is discarded.
- CFG_DUTY > 20 is clamped to 20 at capture.

Optional Feature:
- Macro: WAVE_PHASE_SWEEP_EN.
- With the macro defined:
  - Extra inputs SWEEP_DELTA[15:0] (unsigned) and SWEEP_LIMIT[ACC_WIDTH-1:0].
  - On each WRAP in RUN, active step <= step + SWEEP_DELTA.
  - If the result is > SWEEP_LIMIT, step reloads to the base step, i.e. the last applied CFG_STEP.
  - SWEEP_DELTA = 0 disables sweeping.
  - A pending config applied on the same WRAP takes priority over the sweep.
- Without the macro: the ports are absent and the step changes only via the config handshake.

Test Plan:
- SAMPLE_DIV=4; RESET, then config STEP=0x4000_0000, FORM=0, DUTY=10, ENABLE=1 → PHASE sequence 1024, 2048, 3072, 0 on successive ticks 4 CLK apart; WRAP on the tick where PHASE=0; RUNNING=1.
- Mid-period config STEP=0x8000_0000 offered at PHASE=1024 → CFG_READY drops next cycle. Old step continues to the wrap, then the next PHASE is 2048, then 0 with WRAP. FORM/SQUARE_DUTY change exactly at the wrap tick. CFG_READY returns to 1 the cycle after the apply.
- ENABLE dropped at PHASE=2048 (step 0x4000_0000) → 3072 then 0/WRAP. State goes to IDLE, RUNNING=0, PHASE held at 0 on further ticks.
- Active step=0 while running, new config STEP=0x2000_0000 → applied at the next tick with no WRAP required; PHASE then advances by 512 per tick.
- RESET asserted while STOPPING with a pending entry → the next cycle shows PHASE=0, FORM=0, SQUARE_DUTY=10, CFG_READY=1, RUNNING=0; the pending entry is lost.
- WAVE_PHASE_SWEEP_EN defined; base step 0x1000_0000, DELTA=0x0100, LIMIT=0x1000_0200 → step is 0x1000_0100 after 1st WRAP, 0x1000_0200 after 2nd, and reloads to 0x1000_0000 after 3rd.
